// File: rtl/button_conditioner.sv
// Button conditioner for five pushbuttons (L, R, U, D, C) clocked by a 200 Hz tick.
// Each raw input is synchronized, debounced by its own FSM, and turned into a
// debounced level plus a one-cycle strobe on press acceptance. Buttons enabled in
// REPEAT_MASK also strobe periodically while held.
//
// Parameters:
//   DEBOUNCE_TICKS  consecutive stable samples to accept a press or release
//   REPEAT_DELAY    cycles from press acceptance to the first auto-repeat strobe
//   REPEAT_RATE     cycles between subsequent auto-repeat strobes
//   REPEAT_MASK     per-button auto-repeat enable (bit map as btn_in)
// Ports:
//   clk_200    in   system tick clock, rising edge active
//   rst        in   asynchronous active-high reset
//   btn_in     in   [4:0] raw buttons: bit 0 L, 1 R, 2 U, 3 D, 4 C
//   btn_pulse  out  [4:0] registered one-cycle press / repeat strobes
//   btn_level  out  [4:0] registered debounced pressed level
//   any_pulse  out  registered OR of btn_pulse, same cycle
module button_conditioner #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned REPEAT_DELAY   = 100,
  parameter int unsigned REPEAT_RATE    = 20,
  parameter logic [4:0]  REPEAT_MASK    = 5'b01100
) (
  input  logic       clk_200,
  input  logic       rst,
  input  logic [4:0] btn_in,
  output logic [4:0] btn_pulse,
  output logic [4:0] btn_level,
  output logic       any_pulse
);

  localparam int unsigned NB   = 5;
  localparam int unsigned DT   = (DEBOUNCE_TICKS < 1) ? 1 : DEBOUNCE_TICKS;
  localparam int unsigned RD   = (REPEAT_DELAY < 1) ? 1 : REPEAT_DELAY;
  localparam int unsigned RR   = (REPEAT_RATE < 1) ? 1 : REPEAT_RATE;
  localparam int unsigned RMAX = (RD > RR) ? RD : RR;
  localparam int unsigned DW   = $clog2(DT + 1);
  localparam int unsigned RW   = $clog2(RMAX + 1);

  // Counter values at which the current sample completes the interval.
  localparam logic [DW-1:0] DB_LAST    = DW'(DT - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(RD - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(RR - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DB,
    HELD,
    REL_DB
  } state_t;

  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] pulse_d;

  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= btn_in;
      sync2 <= sync1;
    end
  end

  for (genvar i = 0; i < NB; i++) begin : g_btn
    state_t        state;
    state_t        state_next;
    logic [DW-1:0] db_cnt;
    logic [DW-1:0] db_next;
    logic [RW-1:0] rpt_cnt;
    logic [RW-1:0] rpt_next;
    logic          armed;       // first repeat already issued; later ones use REPEAT_RATE
    logic          armed_next;
    logic          level;
    logic          level_next;
    logic          pulse;
    logic          pulse_next;
    logic          s;

    assign s = sync2[i];

    always_comb begin
      state_next = state;
      db_next    = db_cnt;
      rpt_next   = rpt_cnt;
      armed_next = armed;
      level_next = level;
      pulse_next = 1'b0;
      unique case (state)
        IDLE: begin
          if (s) begin
            if (DT == 1) begin
              state_next = HELD;
              level_next = 1'b1;
              pulse_next = 1'b1;
              rpt_next   = '0;
              armed_next = 1'b0;
            end else begin
              state_next = PRESS_DB;
              db_next    = DW'(1);
            end
          end
        end
        PRESS_DB: begin
          if (!s) begin
            state_next = IDLE;
          end else if (db_cnt >= DB_LAST) begin
            state_next = HELD;
            level_next = 1'b1;
            pulse_next = 1'b1;
            rpt_next   = '0;
            armed_next = 1'b0;
          end else begin
            db_next = db_cnt + DW'(1);
          end
        end
        HELD: begin
          if (!s) begin
            if (DT == 1) begin
              state_next = IDLE;
              level_next = 1'b0;
            end else begin
              state_next = REL_DB;
              db_next    = DW'(1);
            end
          end else if (REPEAT_MASK[i]) begin
            // Reload on every strobe so the counter never runs past its interval.
            if (rpt_cnt >= (armed ? RATE_LAST : DELAY_LAST)) begin
              pulse_next = 1'b1;
              rpt_next   = '0;
              armed_next = 1'b1;
            end else begin
              rpt_next = rpt_cnt + RW'(1);
            end
          end
        end
        REL_DB: begin
          if (s) begin
            // Release bounce: resume the hold with repeat timing restarted, no strobe.
            state_next = HELD;
            rpt_next   = '0;
            armed_next = 1'b0;
          end else if (db_cnt >= DB_LAST) begin
            state_next = IDLE;
            level_next = 1'b0;
          end else begin
            db_next = db_cnt + DW'(1);
          end
        end
        default: state_next = IDLE;
      endcase
    end

    always_ff @(posedge clk_200 or posedge rst) begin
      if (rst) begin
        state   <= IDLE;
        db_cnt  <= '0;
        rpt_cnt <= '0;
        armed   <= 1'b0;
        level   <= 1'b0;
        pulse   <= 1'b0;
      end else begin
        state   <= state_next;
        db_cnt  <= db_next;
        rpt_cnt <= rpt_next;
        armed   <= armed_next;
        level   <= level_next;
        pulse   <= pulse_next;
      end
    end

    assign btn_level[i] = level;
    assign btn_pulse[i] = pulse;
    assign pulse_d[i]   = pulse_next;
  end

  always_ff @(posedge clk_200 or posedge rst) begin
    if (rst) begin
      any_pulse <= 1'b0;
    end else begin
      any_pulse <= |pulse_d;
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: a default-parameter instance plus a second
// instance with single-sample debounce and auto-repeat disabled, both fed the
// same buttons and compared each cycle against a run-length reference model,
// plus a vector table and hand-written press / repeat / reset sequences.
module tb_button_conditioner;

  localparam int DELAY = 100;
  localparam int RATE  = 20;

  logic       clk_200 = 1'b0;
  logic       rst     = 1'b0;
  logic [4:0] btn_in  = '0;
  logic [4:0] pulse0, level0, pulse1, level1;
  logic       any0, any1;

  button_conditioner dut0 (
    .clk_200  (clk_200),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_pulse(pulse0),
    .btn_level(level0),
    .any_pulse(any0)
  );

  button_conditioner #(
    .DEBOUNCE_TICKS(1),
    .REPEAT_DELAY  (DELAY),
    .REPEAT_RATE   (RATE),
    .REPEAT_MASK   (5'b00000)
  ) dut1 (
    .clk_200  (clk_200),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_pulse(pulse1),
    .btn_level(level1),
    .any_pulse(any1)
  );

  initial forever #5 clk_200 = ~clk_200;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  // Reference model: per button, a debounced level, the run length of samples
  // disagreeing with that level, and the time held since acceptance.
  int         mdt [2] = '{4, 1};
  logic [4:0] mmask [2] = '{5'b01100, 5'b00000};
  int         mrun [2][5];
  int         mt [2][5];
  logic [4:0] mlevel [2];
  logic [4:0] exp_pulse [2];
  logic [4:0] exp_level [2];
  logic [4:0] mh1, mh2;

  task automatic model_reset();
    mh1 = '0;
    mh2 = '0;
    for (int p = 0; p < 2; p++) begin
      mlevel[p]    = '0;
      exp_pulse[p] = '0;
      exp_level[p] = '0;
      for (int i = 0; i < 5; i++) begin
        mrun[p][i] = 0;
        mt[p][i]   = 0;
      end
    end
  endtask

  task automatic model_edge(input logic [4:0] s);
    for (int p = 0; p < 2; p++) begin
      exp_pulse[p] = '0;
      for (int i = 0; i < 5; i++) begin
        if (!mlevel[p][i]) begin
          if (s[i]) begin
            mrun[p][i]++;
            if (mrun[p][i] >= mdt[p]) begin
              mlevel[p][i]    = 1'b1;
              mrun[p][i]      = 0;
              mt[p][i]        = 0;
              exp_pulse[p][i] = 1'b1;
            end
          end else begin
            mrun[p][i] = 0;
          end
        end else begin
          if (!s[i]) begin
            mrun[p][i]++;
            if (mrun[p][i] >= mdt[p]) begin
              mlevel[p][i] = 1'b0;
              mrun[p][i]   = 0;
            end
          end else if (mrun[p][i] > 0) begin
            mrun[p][i] = 0;
            mt[p][i]   = 0;
          end else begin
            mt[p][i]++;
            if (mmask[p][i] && mt[p][i] >= DELAY && (mt[p][i] - DELAY) % RATE == 0)
              exp_pulse[p][i] = 1'b1;
          end
        end
      end
      exp_level[p] = mlevel[p];
    end
  endtask

  // Apply b ahead of the next rising edge, advance the model, compare both DUTs.
  task automatic step(input logic [4:0] b);
    logic [4:0] s;
    btn_in = b;
    @(posedge clk_200);
    s   = mh2;
    mh2 = mh1;
    mh1 = b;
    model_edge(s);
    #1;
    check("pulse0", pulse0, exp_pulse[0]);
    check("level0", level0, exp_level[0]);
    check("any0",   any0,   |exp_pulse[0]);
    check("pulse1", pulse1, exp_pulse[1]);
    check("level1", level1, exp_level[1]);
    check("any1",   any1,   |exp_pulse[1]);
  endtask

  task automatic check_zero(input string name);
    check({name, "_pulse0"}, pulse0, 0);
    check({name, "_level0"}, level0, 0);
    check({name, "_any0"},   any0,   0);
    check({name, "_pulse1"}, pulse1, 0);
    check({name, "_level1"}, level1, 0);
    check({name, "_any1"},   any1,   0);
  endtask

  typedef struct {
    logic [4:0] b;
    logic [4:0] pulse;
    logic [4:0] level;
  } vec_t;

  vec_t tbl [22];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [21:0] lin;
    int          first0, first1, np0, np1;
    int          uq [$];
    logic [4:0]  intent, b;

    // Reset with every button pressed: all outputs stay low.
    btn_in = '1;
    model_reset();
    #1 rst = 1'b1;
    #1 check_zero("reset");
    repeat (3) begin
      @(posedge clk_200);
      #1 check_zero("reset_hold");
    end
    @(negedge clk_200);
    btn_in = '0;
    rst    = 1'b0;
    repeat (4) step('0);

    // L bouncing 1,0,1,1,0 then stable: one strobe four stable samples later.
    lin = 22'b00000000_11111111101101;
    for (int t = 0; t < 22; t++) begin
      tbl[t].b     = {4'b0000, lin[t]};
      tbl[t].pulse = (t == 10) ? 5'b00001 : 5'b00000;
      tbl[t].level = (t >= 10 && t <= 18) ? 5'b00001 : 5'b00000;
    end
    for (int t = 0; t < 22; t++) begin
      step(tbl[t].b);
      check("tbl_pulse", pulse0, tbl[t].pulse);
      check("tbl_level", level0, tbl[t].level);
    end

    // C held 50 cycles: one strobe at edge 5, level through release debounce, no repeat.
    np0 = 0; first0 = -1;
    for (int t = 0; t < 60; t++) begin
      step(t < 50 ? 5'b10000 : 5'b00000);
      if (pulse0[4]) begin
        np0++;
        if (first0 < 0) first0 = t;
      end
      if (t == 54) check("c_level_rel_db", level0[4], 1);
      if (t == 55) check("c_level_released", level0[4], 0);
    end
    check("c_pulse_count", np0, 1);
    check("c_pulse_edge", first0, 5);

    // U held so the sample stays 1 through acceptance+150: strobes at A, A+100, A+120, A+140.
    for (int t = 0; t < 166; t++) begin
      step(t < 154 ? 5'b00100 : 5'b00000);
      if (pulse0[2]) uq.push_back(t);
    end
    check("u_pulse_count", uq.size(), 4);
    if (uq.size() == 4) begin
      check("u_pulse_a",     uq[0], 5);
      check("u_pulse_a100",  uq[1], 105);
      check("u_pulse_a120",  uq[2], 125);
      check("u_pulse_a140",  uq[3], 145);
    end

    // D held 300 cycles on the no-repeat, single-sample-debounce instance.
    np1 = 0; first1 = -1;
    for (int t = 0; t < 305; t++) begin
      step(t < 300 ? 5'b01000 : 5'b00000);
      if (pulse1[3]) begin
        np1++;
        if (first1 < 0) first1 = t;
      end
    end
    check("d_norepeat_count", np1, 1);
    check("d_debounce1_edge", first1, 2);

    // L and R rising together strobe in the same cycle.
    for (int t = 0; t < 16; t++) begin
      step(t < 8 ? 5'b00011 : 5'b00000);
      if (t == 5) begin
        check("lr_pulse", pulse0, 5'b00011);
        check("lr_any", any0, 1);
      end
    end

    // Reset mid-hold on U, released with U still pressed: fresh single strobe at edge 5.
    for (int t = 0; t < 20; t++) step(5'b00100);
    check("u_held_before_rst", level0[2], 1);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    repeat (3) begin
      @(posedge clk_200);
      #1 check_zero("midrst_hold");
    end
    @(negedge clk_200);
    rst = 1'b0;
    model_reset();
    np0 = 0; first0 = -1; np1 = 0; first1 = -1;
    for (int t = 0; t < 12; t++) begin
      step(5'b00100);
      if (pulse0[2]) begin np0++; if (first0 < 0) first0 = t; end
      if (pulse1[2]) begin np1++; if (first1 < 0) first1 = t; end
    end
    check("rst_u_count0", np0, 1);
    check("rst_u_edge0", first0, 5);
    check("rst_u_count1", np1, 1);
    check("rst_u_edge1", first1, 2);
    repeat (8) step('0);

    // Randomized presses with bounce glitches, checked cycle by cycle against the model.
    intent = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range((i == 2 || i == 3) ? 249 : 59) == 0) intent[i] = ~intent[i];
      end
      b = intent;
      for (int i = 0; i < 5; i++) begin
        if ($urandom_range(11) == 0) b[i] = ~b[i];
      end
      step(b);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
